// File: rtl/ffd_serial_pkg.sv
// Shared definitions for the serial transmitter and the receiver-side capture block.
// The optional parity window is controlled by FFD_SERIAL_TX_PARITY_EN in the transmitter.
package ffd_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_e;

  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int div_cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/ffd_bit_timer.sv
// Bit-window divider: counts 0..DIV-1 while enabled, flagging the mid-window
// sample point and the last cycle of each window.
module ffd_bit_timer
  import ffd_serial_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic mid,
  output logic last
);

  localparam int DW = div_cnt_w(DIV);
  localparam logic [DW-1:0] MID_CNT  = DW'(DIV / 2);
  localparam logic [DW-1:0] LAST_CNT = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= last ? '0 : div_cnt + 1'b1;
    end
  end

  assign mid  = en && (div_cnt == MID_CNT);
  assign last = en && (div_cnt == LAST_CNT);

endmodule

// File: rtl/ffd_serial_tx.sv
// Parallel-to-serial transmitter feeding the enabled flip-flop capture chain.
// Define FFD_SERIAL_TX_PARITY_EN to append an even-parity window to every frame.
module ffd_serial_tx
  import ffd_serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DIV       = DEFAULT_DIV,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] datos_in,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

`ifdef FFD_SERIAL_TX_PARITY_EN
  localparam int NUM_WIN = WIDTH + 1;
`else
  localparam int NUM_WIN = WIDTH;
`endif
  localparam int BW = bit_cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_WIN = BW'(NUM_WIN - 1);

  tx_state_e        state, next_state;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic             accept;
  logic             in_shift;
  logic             win_mid;
  logic             win_last;
  logic             data_bit;
  logic             cur_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (win_last && (bit_cnt == LAST_WIN)) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_shift = (state == SHIFT);

  ffd_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .en    (in_shift),
    .clr   (accept),
    .mid   (win_mid),
    .last  (win_last)
  );

  assign data_bit = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      shift_reg <= datos_in;
      bit_cnt   <= '0;
    end else if (in_shift && win_last) begin
      shift_reg <= (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);
      bit_cnt   <= (bit_cnt == LAST_WIN) ? '0 : bit_cnt + 1'b1;
    end
  end

`ifdef FFD_SERIAL_TX_PARITY_EN
  // Parity is taken from the word as captured, not from the shifting copy.
  logic parity_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^datos_in;
    end
  end

  assign cur_bit = (bit_cnt == BW'(WIDTH)) ? parity_bit : data_bit;
`else
  assign cur_bit = data_bit;
`endif

  // Outputs are registered one cycle behind the state so the receiver sees glitch-free lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      ser_out <= 1'b0;
      ser_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      ser_out <= in_shift & cur_bit;
      ser_en  <= in_shift & win_mid;
      busy    <= in_shift;
      done    <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_ffd_serial_tx.sv
// Self-checking bench for ffd_serial_tx: MSB-first and LSB-first instances driven
// together and compared every cycle against a frame-timing reference model.
module tb_ffd_serial_tx;
  import ffd_serial_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;
  localparam int DIV   = DEFAULT_DIV;
`ifdef FFD_SERIAL_TX_PARITY_EN
  localparam int NWIN = WIDTH + 1;
`else
  localparam int NWIN = WIDTH;
`endif
  localparam int FRAME = NWIN * DIV;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] datos_in;
  logic             ser_out_m, ser_en_m, busy_m, done_m;
  logic             ser_out_l, ser_en_l, busy_l, done_l;

  int               checks = 0;
  int               errors = 0;

  int               edge_n = -1;
  int               frame_edge = 0;
  int               free_edge = 0;
  bit               active = 1'b0;
  logic [WIDTH-1:0] word = '0;
  logic [WIDTH-1:0] rx_word = '0;
  int               rx_cnt = 0;

  always #5 clk = ~clk;

  ffd_serial_tx #(.WIDTH(WIDTH), .DIV(DIV), .MSB_FIRST(1)) dut_msb (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .datos_in (datos_in),
    .ser_out  (ser_out_m),
    .ser_en   (ser_en_m),
    .busy     (busy_m),
    .done     (done_m)
  );

  ffd_serial_tx #(.WIDTH(WIDTH), .DIV(DIV), .MSB_FIRST(0)) dut_lsb (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .datos_in (datos_in),
    .ser_out  (ser_out_l),
    .ser_en   (ser_en_l),
    .busy     (busy_l),
    .done     (done_l)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  // Expected outputs follow from the time elapsed since the accepting edge.
  task automatic check_output();
    int   rel, win, ph;
    logic e_busy, e_en, e_done, e_msb, e_lsb;
    e_busy = 1'b0; e_en = 1'b0; e_done = 1'b0; e_msb = 1'b0; e_lsb = 1'b0;
    rel = edge_n - frame_edge;
    if (active && rel >= 1 && rel <= FRAME) begin
      win    = (rel - 1) / DIV;
      ph     = (rel - 1) % DIV;
      e_busy = 1'b1;
      e_en   = (ph == DIV / 2);
      if (win < WIDTH) begin
        e_msb = word[WIDTH-1-win];
        e_lsb = word[win];
      end else begin
        e_msb = ^word;
        e_lsb = ^word;
      end
    end
    if (active && rel == FRAME + 1) e_done = 1'b1;

    check_val("busy_msb",    32'(busy_m),    32'(e_busy));
    check_val("ser_en_msb",  32'(ser_en_m),  32'(e_en));
    check_val("ser_out_msb", 32'(ser_out_m), 32'(e_msb));
    check_val("done_msb",    32'(done_m),    32'(e_done));
    check_val("busy_lsb",    32'(busy_l),    32'(e_busy));
    check_val("ser_en_lsb",  32'(ser_en_l),  32'(e_en));
    check_val("ser_out_lsb", 32'(ser_out_l), 32'(e_lsb));
    check_val("done_lsb",    32'(done_l),    32'(e_done));

    // Receiver-style reassembly of the LSB-first line using the DUT's own strobes.
    if (ser_en_l === 1'b1) begin
      if (rx_cnt < WIDTH) rx_word[rx_cnt] = ser_out_l;
      rx_cnt++;
    end
    if (e_done) begin
      check_val("rx_word", 32'(rx_word), 32'(word));
      check_val("rx_pulses", 32'(rx_cnt), 32'(NWIN));
      rx_cnt = 0;
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic [WIDTH-1:0] d);
    @(negedge clk);
    reset    = r;
    start    = s;
    datos_in = d;
    @(posedge clk);
    edge_n++;
    if (r) begin
      active    = 1'b0;
      free_edge = edge_n + 1;
      rx_cnt    = 0;
    end else if (s && edge_n >= free_edge) begin
      active     = 1'b1;
      frame_edge = edge_n;
      word       = d;
      free_edge  = edge_n + FRAME + 2;
      rx_cnt     = 0;
      rx_word    = '0;
    end
    #1;
    check_output();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    datos_in = '0;

    $display("[TB] reset and idle");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] directed frame 8'hA5");
    apply_stimulus(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < FRAME + 3; i++) apply_stimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] directed frame 8'h01");
    apply_stimulus(1'b0, 1'b1, 8'h01);
    for (int i = 0; i < FRAME + 3; i++) apply_stimulus(1'b0, 1'b0, 8'hFF);

    $display("[TB] start held high with changing data");
    for (int i = 0; i < 3 * (FRAME + 2) + 4; i++)
      apply_stimulus(1'b0, 1'b1, WIDTH'($urandom));
    for (int i = 0; i < FRAME + 3; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] reset in the middle of a frame");
    apply_stimulus(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 14; i++) apply_stimulus(1'b0, 1'b0, WIDTH'($urandom));
    apply_stimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, WIDTH'($urandom));
    for (int i = 0; i < FRAME + 3; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] frame 8'h07 (parity window when enabled)");
    apply_stimulus(1'b0, 1'b1, 8'h07);
    for (int i = 0; i < FRAME + 3; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      apply_stimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
                     WIDTH'($urandom));
    for (int i = 0; i < FRAME + 3; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
